// File: rtl/booth_divider_seq.sv
// booth_divider_seq: signed restoring divider, one quotient bit per clock, sign fix-up at the end.
// Result = {remainder, quotient}; divide-by-zero gives {dividend, all ones} and raises div_by_zero.
`timescale 1ns/1ps
module booth_divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t               state_q, state_d;
    logic                 sgn_quo_q, sgn_quo_d;
    logic                 sgn_rem_q, sgn_rem_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH:0]       dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       dvs_ext, dvs_mag, shifted;
    logic [WIDTH-1:0]     dvd_mag, quo_fix, rem_fix;
    logic                 ge;

    // Divisor magnitude is W+1 bits so |0x80000000| stays exact.
    assign dvs_ext = {divisor[WIDTH-1], divisor};
    assign dvs_mag = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= dvs_q;
    assign quo_fix = sgn_quo_q ? -quo_q : quo_q;
    assign rem_fix = sgn_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        zero_d    = zero_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: if (start) begin
                sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                sgn_rem_d = dividend[WIDTH-1];
                zero_d    = divisor == '0;
                dvd_d     = dividend;
                dvs_d     = dvs_mag;
                quo_d     = dvd_mag;
                rem_d     = '0;
                cnt_d     = '0;
                busy_d    = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                rem_d   = ge ? WIDTH'(shifted - dvs_q) : shifted[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ge};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIXUP : RUN;
            end
            FIXUP: begin
                result_d = zero_q ? {dvd_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
                dbz_d    = zero_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            zero_q    <= zero_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign Result      = result_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_booth_divider_seq.sv
// tb_booth_divider_seq: directed bench for booth_divider_seq with a result scoreboard.
`timescale 1ns/1ps
module tb_booth_divider_seq;
    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [63:0] Result;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int failures = 0;
    logic [64:0] sb[$];
    logic [64:0] exp_e;
    int cyc, bcyc, ndone;

    booth_divider_seq #(.WIDTH(32)) dut (
        .clock(clock), .clear_n(clear_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .Result(Result), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_done();
        cyc = 0;
        bcyc = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            if (busy) bcyc++;
        end
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp_e = sb.pop_front();
            chk({tag, "_result"}, Result, exp_e[63:0]);
            chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_e[64]));
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] er, input logic ed);
        @(negedge clock);
        dividend = a;
        divisor = b;
        start = 1'b1;
        sb.push_back({ed, er});
        @(posedge clock); #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        chk({tag, "_busy_accept"}, 64'(busy), 64'd1);
        wait_done();
        check_result(tag);
        chk({tag, "_busy_cycles"}, 64'(bcyc), 64'd33);
        @(posedge clock); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_result", Result, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;

        do_op("p100_7",  32'd100,       32'd7,          64'h00000002_0000000E, 1'b0);
        do_op("n100_7",  -32'sd100,     32'd7,          64'hFFFFFFFE_FFFFFFF2, 1'b0);
        do_op("p100_n7", 32'd100,       -32'sd7,        64'h00000002_FFFFFFF2, 1'b0);
        do_op("n100_n7", -32'sd100,     -32'sd7,        64'hFFFFFFFE_0000000E, 1'b0);
        do_op("dbz",     32'h12345678,  32'd0,          64'h12345678_FFFFFFFF, 1'b1);
        do_op("after_dbz", 32'd6,       32'd3,          64'h00000000_00000002, 1'b0);
        do_op("min_n1",  32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 1'b0);
        do_op("min_1",   32'h80000000,  32'd1,          64'h00000000_80000000, 1'b0);
        do_op("max_max", 32'h7FFFFFFF,  32'h7FFFFFFF,   64'h00000000_00000001, 1'b0);
        do_op("p5_9",    32'd5,         32'd9,          64'h00000005_00000000, 1'b0);

        // start held high with operands churning every RUN cycle
        @(negedge clock);
        dividend = 32'd6;
        divisor = 32'd3;
        start = 1'b1;
        sb.push_back({1'b0, 64'h00000000_00000002});
        @(posedge clock); #1;
        chk("hs_busy_accept", 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            dividend = $urandom;
            divisor = $urandom;
            @(posedge clock); #1;
            cyc++;
        end
        check_result("hs_first");
        dividend = 32'd20;
        divisor = 32'd4;
        sb.push_back({1'b0, 64'h00000000_00000005});
        @(posedge clock); #1;
        start = 1'b0;
        chk("hs_back_to_back", {62'd0, busy, done}, 64'd2);
        wait_done();
        check_result("hs_second");

        // asynchronous reset in the middle of RUN
        @(negedge clock);
        dividend = 32'd1000;
        divisor = 32'd3;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 clear_n = 1'b0;
        #1;
        chk("abort_result", Result, 64'd0);
        chk("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        ndone = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        do_op("after_abort", 32'd20, 32'd3, 64'h00000002_00000006, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Multi-cycle signed 32-bit integer divider; the inverse of the combinational Booth multiplier on the ALU's MUL path.
- Serves the DIV instruction: takes dividend and divisor, produces {remainder, quotient} for HI/LO.
- Restoring shift-subtract on magnitudes, one quotient bit per clock, sign fix-up at end.
- start/busy/done handshake toward the control sequencer.

Parameters:
WIDTH, 32, operand width; Result is 2*WIDTH; latency is WIDTH+1 cycles.

Ports:
clock  in  1  system clock, rising edge.
clear_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
dividend  in  WIDTH  signed dividend, sampled on the accepting edge.
divisor  in  WIDTH  signed divisor, sampled on the accepting edge.
Result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; HI=remainder, LO=quotient.
busy  out  1  high from accepting edge until done.
done  out  1  one-cycle pulse when Result is updated.
div_by_zero  out  1  status of last completed operation; divisor was 0.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - Result=0, busy=0, done=0, div_by_zero=0.
  - State IDLE; all internal registers cleared.
  - Mid-operation reset aborts; no done is issued.
- States IDLE -> RUN -> FIXUP -> IDLE.
- IDLE:
  - On an edge with start=1, latch sign_q = dividend[W-1]^divisor[W-1] and sign_r = dividend[W-1].
  - Latch zero flag (divisor==0), |dividend|, |divisor| (W+1-bit magnitudes so 0x80000000 is exact).
  - Clear partial remainder and iteration counter; busy=1; go to RUN.
- RUN, WIDTH cycles, counter 0..W-1:
  - Shift {rem, quo} left by 1, MSB of quo into rem.
  - Trial = rem - |divisor|, W+1 bits.
  - If trial >= 0: rem = trial, quo[0] = 1; else quo[0] = 0.
  - After count W-1, go to FIXUP.
- FIXUP, 1 cycle:
  - quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem; both truncated to W bits.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - If zero flag: quotient = all ones, remainder = original dividend, div_by_zero=1; else div_by_zero=0.
  - Register Result; done=1 for exactly this cycle's following clock period; busy=0; go to IDLE.
- Latency: accepting edge T0, done high after edge T(W+1) = T33; fixed for all operands including divide-by-zero.
- Result and div_by_zero hold until the next FIXUP or reset.
- start while busy: ignored; no queueing; operands not re-sampled.
- start on the same edge that done deasserts (state IDLE): accepted; back-to-back throughput one op per W+2 cycles.
- Overflow 0x80000000 / -1: quotient 0x80000000 (two's-complement wrap), remainder 0, no flag.
- Inputs dividend/divisor may change freely while busy without affecting the result.

Test Plan:
- 100 / 7 -> after 33 cycles, done pulse; Result=0x00000002_0000000E; busy high for exactly 33 cycles; div_by_zero=0.
- Sign matrix:
  - -100/7 -> 0xFFFFFFFE_FFFFFFF2.
  - 100/-7 -> 0x00000002_FFFFFFF2.
  - -100/-7 -> 0xFFFFFFFE_0000000E.
- Divide by zero: 0x12345678 / 0 -> Result=0x12345678_FFFFFFFF, div_by_zero=1, same 33-cycle latency; following 6/3 -> 0x00000000_00000002, div_by_zero=0.
- Extremes:
  - 0x80000000 / -1 -> 0x00000000_80000000.
  - 0x80000000 / 1 -> 0x00000000_80000000.
  - 0x7FFFFFFF / 0x7FFFFFFF -> 0x00000000_00000001.
  - 5 / 9 -> 0x00000005_00000000.
- Handshake: hold start high with operands changing every cycle during RUN -> only the first operands are used, one done per op, next op accepted immediately after done.
- Reset mid-op: assert clear_n=0 at cycle 10 of RUN -> Result=0, busy=0, done=0 asynchronously, no done later; a subsequent 20/3 returns 0x00000002_00000006.
